// File: rtl/instr_decode_stage.sv
// Decode stage: registers one decoded instruction bundle between fetch and execute,
// inserting a single bubble on load-use hazards and dropping its contents on flush.
module instr_decode_stage #(
  parameter int IMM_W = 8,
  parameter int PC_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [2:0]       alu_op,
  output logic [2:0]       rd_addr,
  output logic [2:0]       rs_addr,
  output logic [2:0]       rt_addr,
  output logic [IMM_W-1:0] imm,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src_imm,
  output logic             branch,
  output logic             jump,
  output logic             illegal,
  output logic [7:0]       stall_count
);

  typedef struct packed {
    logic [2:0]       alu_op;
    logic [2:0]       rd;
    logic [2:0]       rs;
    logic [2:0]       rt;
    logic [IMM_W-1:0] imm;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src_imm;
    logic             branch;
    logic             jump;
    logic             illegal;
  } dec_t;

  dec_t            w_dec;
  logic            w_use_rs, w_use_rt, w_hazard;
  dec_t            r_out;
  logic            r_valid;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_stall;

  always_comb begin
    w_dec    = '0;
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    case (in_instr[15:12])
      4'b0000: begin
        w_dec.rd = in_instr[11:9];
        w_dec.rs = in_instr[8:6];
        w_dec.rt = in_instr[5:3];
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        // funct 111 is the NOP encoding: no write, ALU op left at ADD
        if (in_instr[2:0] != 3'b111) begin
          w_dec.alu_op    = in_instr[2:0];
          w_dec.reg_write = 1'b1;
        end
      end
      4'b0100, 4'b1011: begin
        w_dec.rd          = in_instr[11:9];
        w_dec.rs          = in_instr[8:6];
        w_dec.imm         = IMM_W'($signed(in_instr[5:0]));
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_dec.mem_read    = in_instr[15];
        w_use_rs          = 1'b1;
      end
      4'b1111: begin
        w_dec.rt          = in_instr[11:9];
        w_dec.rs          = in_instr[8:6];
        w_dec.imm         = IMM_W'($signed(in_instr[5:0]));
        w_dec.alu_src_imm = 1'b1;
        w_dec.mem_write   = 1'b1;
        w_use_rs          = 1'b1;
        w_use_rt          = 1'b1;
      end
      4'b1000: begin
        w_dec.rs     = in_instr[11:9];
        w_dec.rt     = in_instr[8:6];
        w_dec.imm    = IMM_W'($signed(in_instr[5:0]));
        w_dec.alu_op = 3'b001;
        w_dec.branch = 1'b1;
        w_use_rs     = 1'b1;
        w_use_rt     = 1'b1;
      end
      4'b0010: begin
        w_dec.imm  = IMM_W'(in_instr[7:0]);
        w_dec.jump = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  assign w_hazard = r_valid & r_out.mem_read & in_valid &
                    ((w_use_rs & (w_dec.rs == r_out.rd)) |
                     (w_use_rt & (w_dec.rt == r_out.rd)));

  assign in_ready = !flush & !w_hazard & (!r_valid | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_pc    <= '0;
      r_stall <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_hazard && out_ready) begin
      // LW leaves this cycle; a flag-free bubble takes its place
      r_valid             <= 1'b0;
      r_out.reg_write     <= 1'b0;
      r_out.mem_read      <= 1'b0;
      r_out.mem_write     <= 1'b0;
      r_out.alu_src_imm   <= 1'b0;
      r_out.branch        <= 1'b0;
      r_out.jump          <= 1'b0;
      r_out.illegal       <= 1'b0;
      if (r_stall != 8'hFF) r_stall <= r_stall + 8'd1;
    end else if (in_valid && in_ready) begin
      r_valid <= 1'b1;
      r_out   <= w_dec;
      r_pc    <= in_pc;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign alu_op      = r_out.alu_op;
  assign rd_addr     = r_out.rd;
  assign rs_addr     = r_out.rs;
  assign rt_addr     = r_out.rt;
  assign imm         = r_out.imm;
  assign reg_write   = r_out.reg_write;
  assign mem_read    = r_out.mem_read;
  assign mem_write   = r_out.mem_write;
  assign alu_src_imm = r_out.alu_src_imm;
  assign branch      = r_out.branch;
  assign jump        = r_out.jump;
  assign illegal     = r_out.illegal;
  assign stall_count = r_stall;

endmodule
